// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants and word helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rcon_word(input logic [3:0] r);
    rcon_word = {rcon(r), 24'h000000};
  endfunction

  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] i);
    case (i)
      2'd0:    key_word = k[127:96];
      2'd1:    key_word = k[95:64];
      2'd2:    key_word = k[63:32];
      default: key_word = k[31:0];
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  // Row r of the table holds the substitutions for inputs 16*r .. 16*r+15.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_out = SBOX[i_in];

endmodule

// File: rtl/ters_anahtar_uretici.sv
// Reverse-order AES-128 round-key generator: expands the cipher key forward
// to round key 10, then streams keys 10..0 by undoing the schedule one round
// per accepted key.
module ters_anahtar_uretici
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_index,
  output logic             rk_last,
  output logic             done
);

  state_t           r_state;
  logic [KEY_W-1:0] r_key;
  logic [3:0]       r_cnt;
  logic [3:0]       r_rkIndex;
  logic             r_busy;
  logic             r_valid;
  logic             r_last;
  logic             r_done;

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_w1p, w_w2p, w_w3p;
  logic [31:0] w_sboxIn, w_sub, w_rconWord;
  logic [31:0] w_f0, w_f1, w_f2, w_f3, w_b0;
  logic [KEY_W-1:0] w_fwdKey, w_bwdKey;
  logic             w_handshake;

  assign w_w0 = key_word(r_key, 2'd0);
  assign w_w1 = key_word(r_key, 2'd1);
  assign w_w2 = key_word(r_key, 2'd2);
  assign w_w3 = key_word(r_key, 2'd3);

  // Backward step recovers the previous key's last three words by pairwise XOR.
  assign w_w3p = w_w3 ^ w_w2;
  assign w_w2p = w_w2 ^ w_w1;
  assign w_w1p = w_w1 ^ w_w0;

  // One SubWord datapath serves both directions; only its input and RCON index differ.
  assign w_sboxIn   = (r_state == ST_EMIT) ? rot_word(w_w3p) : rot_word(w_w3);
  assign w_rconWord = (r_state == ST_EMIT) ? rcon_word(r_rkIndex) : rcon_word(r_cnt);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_in  (w_sboxIn[8*g +: 8]),
      .o_out (w_sub[8*g +: 8])
    );
  end

  assign w_f0     = w_w0 ^ w_sub ^ w_rconWord;
  assign w_f1     = w_w1 ^ w_f0;
  assign w_f2     = w_w2 ^ w_f1;
  assign w_f3     = w_w3 ^ w_f2;
  assign w_fwdKey = {w_f0, w_f1, w_f2, w_f3};

  assign w_b0     = w_w0 ^ w_sub ^ w_rconWord;
  assign w_bwdKey = {w_b0, w_w1p, w_w2p, w_w3p};

  assign w_handshake = r_valid && rk_ready;

  // Control FSM plus key register; every output is a register so the consumer sees clean timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_key     <= '0;
      r_cnt     <= 4'd0;
      r_rkIndex <= 4'd0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key   <= key_in;
            r_cnt   <= 4'd1;
            r_busy  <= 1'b1;
            r_state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          r_key <= w_fwdKey;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(NR)) begin
            r_rkIndex <= 4'(NR);
            r_valid   <= 1'b1;
            r_state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_handshake) begin
            if (r_rkIndex != 4'd0) begin
              r_key     <= w_bwdKey;
              r_rkIndex <= r_rkIndex - 4'd1;
              r_last    <= (r_rkIndex == 4'd1);
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign rk_out   = r_key;
  assign rk_index = r_rkIndex;
  assign rk_last  = r_last;
  assign done     = r_done;

endmodule

// File: tb/tb_ters_anahtar_uretici.sv
// Scoreboard bench for the reverse round-key generator: stimulus pushes the
// expected key stream, a negedge monitor pops and compares on each handshake.
module tb_ters_anahtar_uretici;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] KEY2_R10 = 128'h28fddef86da4244accc0a4fe3b316f26;

  localparam logic [127:0] RK1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chkKey;
  } sbEntry_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         startIn;
  logic [127:0] keyIn;
  logic         busy;
  logic         rkValid;
  logic         rkReady;
  logic [127:0] rkOut;
  logic [3:0]   rkIndex;
  logic         rkLast;
  logic         done;

  int checks = 0;
  int errors = 0;
  sbEntry_t sbQ[$];
  sbEntry_t sbHead;

  ters_anahtar_uretici dut (
    .clk      (clock),
    .rst      (reset),
    .start    (startIn),
    .key_in   (keyIn),
    .busy     (busy),
    .rk_valid (rkValid),
    .rk_ready (rkReady),
    .rk_out   (rkOut),
    .rk_index (rkIndex),
    .rk_last  (rkLast),
    .done     (done)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] key);
    startIn = 1'b1;
    keyIn   = key;
    tick();
    startIn = 1'b0;
  endtask

  task automatic pushKey1(input int hi, input int lo);
    for (int r = hi; r >= lo; r--) sbQ.push_back('{4'(r), RK1[r], 1'b1});
  endtask

  task automatic pushKey2();
    for (int r = 10; r >= 0; r--) begin
      if (r == 10)     sbQ.push_back('{4'(r), KEY2_R10, 1'b1});
      else if (r == 0) sbQ.push_back('{4'(r), KEY2, 1'b1});
      else             sbQ.push_back('{4'(r), 128'h0, 1'b0});
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".busy"},    128'(busy),    128'h0);
    checkOutput({tag, ".valid"},   128'(rkValid), 128'h0);
    checkOutput({tag, ".last"},    128'(rkLast),  128'h0);
    checkOutput({tag, ".done"},    128'(done),    128'h0);
    checkOutput({tag, ".rkOut"},   rkOut,         128'h0);
    checkOutput({tag, ".rkIndex"}, 128'(rkIndex), 128'h0);
  endtask

  task automatic waitForIndex(input logic [3:0] idx);
    int n = 0;
    while (!(rkValid && rkIndex == idx) && n < 40) begin
      tick();
      n++;
    end
    checkOutput("waitIndex", 128'(n < 40), 128'h1);
  endtask

  task automatic runToDone();
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    checkOutput("doneSeen", 128'(n < 60), 128'h1);
  endtask

  // Monitor: every accepted key is compared with the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && rkValid && rkReady) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedKey", 128'(rkIndex), 128'hf);
      end else begin
        sbHead = sbQ.pop_front();
        checkOutput("rkIndex", 128'(rkIndex), 128'(sbHead.idx));
        checkOutput("rkLast", 128'(rkLast), 128'(sbHead.idx == 4'd0));
        if (sbHead.chkKey) checkOutput("rkOut", rkOut, sbHead.key);
      end
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, firstValid, busyCnt, validCnt;
    bit seenDone, newRun;

    reset   = 1'b1;
    startIn = 1'b0;
    keyIn   = '0;
    rkReady = 1'b0;
    tick();
    tick();
    checkReset("reset");
    reset = 1'b0;
    tick();

    // FIPS-197 key with full-rate consumer: latency, throughput and busy length.
    $display("[TB] run 1: FIPS-197 key, rk_ready held high");
    pushKey1(10, 0);
    rkReady = 1'b1;
    applyStimulus(KEY1);
    c = 1; firstValid = 0; busyCnt = 0; validCnt = 0; seenDone = 1'b0;
    while (!seenDone && c < 60) begin
      if (rkValid && firstValid == 0) firstValid = c;
      if (busy) busyCnt++;
      if (rkValid) validCnt++;
      if (done) seenDone = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    checkOutput("firstValidCycle", 128'(firstValid), 128'd11);
    checkOutput("validCycles", 128'(validCnt), 128'd11);
    checkOutput("busyCycles", 128'(busyCnt), 128'd21);
    checkOutput("doneCycle", 128'(c), 128'd22);
    checkOutput("doneValidLow", 128'(rkValid), 128'h0);
    checkOutput("keepKey0", rkOut, KEY1);
    tick();
    checkOutput("donePulseOnce", 128'(done), 128'h0);

    // Second known-answer key.
    $display("[TB] run 2: Thats my Kung Fu key");
    pushKey2();
    applyStimulus(KEY2);
    runToDone();
    checkOutput("key2Keep", rkOut, KEY2);
    tick();

    // Backpressure at index 7.
    $display("[TB] run 3: backpressure at index 7");
    pushKey1(10, 0);
    applyStimulus(KEY1);
    waitForIndex(4'd7);
    rkReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallKey", rkOut, RK1[7]);
      checkOutput("stallIndex", 128'(rkIndex), 128'd7);
      checkOutput("stallValid", 128'(rkValid), 128'h1);
      tick();
    end
    rkReady = 1'b1;
    runToDone();
    tick();

    // Reset in the middle of expansion.
    $display("[TB] run 4: reset mid-EXPAND and mid-EMIT");
    applyStimulus(KEY1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checkReset("rstExpand");
    reset = 1'b0;
    tick();
    checkOutput("idleAfterRst", 128'(busy), 128'h0);

    // Reset while key 5 is on offer; keys 10..6 are consumed first.
    pushKey1(10, 6);
    applyStimulus(KEY1);
    waitForIndex(4'd5);
    reset   = 1'b1;
    rkReady = 1'b0;
    tick();
    checkReset("rstEmit");
    reset   = 1'b0;
    rkReady = 1'b1;
    tick();
    checkOutput("queueAfterRst", 128'(sbQ.size()), 128'd0);
    pushKey1(10, 0);
    applyStimulus(KEY1);
    runToDone();
    tick();

    // Stray starts are ignored; a start in the done cycle launches the next run.
    $display("[TB] run 5: stray start pulses");
    pushKey1(10, 0);
    applyStimulus(KEY1);
    c = 1; newRun = 1'b0;
    while (!newRun && c < 60) begin
      keyIn   = KEY2;
      startIn = (c == 3) || (c == 15) || (rkValid && rkIndex == 4'd0);
      if (done) begin
        pushKey2();
        startIn = 1'b1;
        newRun  = 1'b1;
      end
      tick();
      startIn = 1'b0;
      c++;
    end
    checkOutput("restartInDone", 128'(newRun), 128'h1);
    checkOutput("busyAfterRestart", 128'(busy), 128'h1);
    runToDone();
    tick();

    checkOutput("queueEmpty", 128'(sbQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
